// File: rtl/subcarrier_nco.sv
// Colour-subcarrier NCO: per-line tuning word, quadrature sine/cosine from a quarter-wave ROM,
// and the line-locked burst gate that tells the loop filter when to accumulate phase error.
module subcarrier_nco #(
    parameter int                 PHASE_W      = 32,
    parameter logic [PHASE_W-1:0] NOMINAL_FTW  = PHASE_W'(569408543),
    parameter int                 OFFSET_LIMIT = 16777216,
    parameter int                 LUT_ADDR_W   = 8,
    parameter int                 OUT_W        = 12,
    parameter int                 BURST_START  = 40,
    parameter int                 BURST_LEN    = 60,
    parameter int                 MAX_LINE     = 2048
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hsync,
    input  logic signed [31:0]      offset_in,
    output logic                    burst_active,
    output logic signed [OUT_W-1:0] sin_out,
    output logic signed [OUT_W-1:0] cos_out,
    output logic [PHASE_W-1:0]      phase_out,
    output logic                    sync_lost
);
    localparam int                 LUT_SIZE = 2 ** LUT_ADDR_W;
    localparam int                 CNT_W    = $clog2(MAX_LINE + 1);
    localparam real                HALF_PI  = 1.5707963267948966;
    localparam real                AMP      = real'(2 ** (OUT_W - 1) - 1);
    localparam logic [PHASE_W-1:0] QUARTER  = PHASE_W'(1) << (PHASE_W - 2);

    typedef enum logic [1:0] {ST_IDLE, ST_PORCH, ST_BURST, ST_WAIT} state_t;

    function automatic logic signed [31:0] clamp_offset(input logic signed [31:0] v);
        if (v > OFFSET_LIMIT)
            return OFFSET_LIMIT;
        if (v < -OFFSET_LIMIT)
            return -OFFSET_LIMIT;
        return v;
    endfunction

    // Odd quadrants read the quarter wave backwards.
    function automatic logic [LUT_ADDR_W-1:0] quarter_idx(input logic [PHASE_W-1:0] ph);
        logic [LUT_ADDR_W-1:0] idx;
        idx = ph[PHASE_W-3 -: LUT_ADDR_W];
        return ph[PHASE_W-2] ? ~idx : idx;
    endfunction

    function automatic logic signed [OUT_W-1:0] apply_sign(input logic [OUT_W-1:0] mag,
                                                           input logic neg);
        return neg ? -$signed(mag) : $signed(mag);
    endfunction

    // Quarter-wave ROM sampled at bin centres; sine evaluated by a Taylor series at elaboration.
    logic [OUT_W-1:0] rom [LUT_SIZE];
    for (genvar i = 0; i < LUT_SIZE; i++) begin : g_rom
        localparam real X  = HALF_PI * (i + 0.5) / LUT_SIZE;
        localparam real X2 = X * X;
        localparam real S  = X * (1.0 - X2 / 6.0 * (1.0 - X2 / 20.0 * (1.0 - X2 / 42.0 *
                             (1.0 - X2 / 72.0 * (1.0 - X2 / 110.0 * (1.0 - X2 / 156.0 *
                             (1.0 - X2 / 210.0)))))));
        assign rom[i] = OUT_W'($rtoi(AMP * S + 0.5));
    end

    logic               hsync_d;
    logic               hsync_rise;
    logic               line_timeout;
    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [CNT_W-1:0]   line_timer;
    logic [PHASE_W-1:0] ftw;
    logic [PHASE_W-1:0] phase_acc;
    logic [PHASE_W-1:0] cos_phase;

    assign hsync_rise   = hsync & ~hsync_d;
    assign line_timeout = ~hsync_rise & (line_timer == CNT_W'(MAX_LINE - 1));
    assign burst_active = (state_q == ST_BURST);
    assign phase_out    = phase_acc;
    assign cos_phase    = phase_acc + QUARTER;

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        if (hsync_rise) begin
            state_nxt = ST_PORCH;
            cnt_nxt   = '0;
        end else if (line_timeout) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state_q)
                ST_PORCH: begin
                    if (cnt_q == CNT_W'(BURST_START - 1)) begin
                        state_nxt = ST_BURST;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                ST_BURST: begin
                    if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_d    <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            line_timer <= CNT_W'(MAX_LINE);
            sync_lost  <= 1'b1;
            ftw        <= NOMINAL_FTW;
            phase_acc  <= '0;
        end else begin
            hsync_d   <= hsync;
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            phase_acc <= phase_acc + ftw;
            if (hsync_rise) begin
                line_timer <= '0;
                sync_lost  <= 1'b0;
                ftw        <= NOMINAL_FTW + PHASE_W'(clamp_offset(offset_in));
            end else if (line_timeout) begin
                line_timer <= CNT_W'(MAX_LINE);
                sync_lost  <= 1'b1;
                ftw        <= NOMINAL_FTW;
            end else if (line_timer != CNT_W'(MAX_LINE)) begin
                line_timer <= line_timer + 1'b1;
            end
        end
    end

    logic [LUT_ADDR_W-1:0] sin_idx_p0, cos_idx_p0;
    logic                  sin_neg_p0, cos_neg_p0, sin_neg_p1, cos_neg_p1;
    logic [OUT_W-1:0]      sin_mag_p1, cos_mag_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sin_idx_p0 <= '0;
            cos_idx_p0 <= '0;
            sin_neg_p0 <= 1'b0;
            cos_neg_p0 <= 1'b0;
            sin_mag_p1 <= '0;
            cos_mag_p1 <= '0;
            sin_neg_p1 <= 1'b0;
            cos_neg_p1 <= 1'b0;
            sin_out    <= '0;
            cos_out    <= '0;
        end else begin
            // p0: quadrant fold
            sin_idx_p0 <= quarter_idx(phase_acc);
            cos_idx_p0 <= quarter_idx(cos_phase);
            sin_neg_p0 <= phase_acc[PHASE_W-1];
            cos_neg_p0 <= cos_phase[PHASE_W-1];
            // p1: ROM read
            sin_mag_p1 <= rom[sin_idx_p0];
            cos_mag_p1 <= rom[cos_idx_p0];
            sin_neg_p1 <= sin_neg_p0;
            cos_neg_p1 <= cos_neg_p0;
            // p2: sign restore
            sin_out    <= apply_sign(sin_mag_p1, sin_neg_p1);
            cos_out    <= apply_sign(cos_mag_p1, cos_neg_p1);
        end
    end
endmodule

// File: tb/tb_subcarrier_nco.sv
// Randomised bench for subcarrier_nco against a line-position/phase reference model.
module tb_subcarrier_nco;
    localparam logic [31:0] NOM    = 32'd569408543;
    localparam int          LIMIT  = 16777216;
    localparam int          BSTART = 40;
    localparam int          BLEN   = 60;
    localparam int          MAXL   = 2048;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               hsync = 1'b0;
    logic signed [31:0] offset_in = '0;
    logic               burst_active;
    logic signed [11:0] sin_out, cos_out;
    logic [31:0]        phase_out;
    logic               sync_lost;

    int n_checks = 0;
    int n_pass   = 0;

    subcarrier_nco dut (
        .clk(clk), .rst(rst), .hsync(hsync), .offset_in(offset_in),
        .burst_active(burst_active), .sin_out(sin_out), .cos_out(cos_out),
        .phase_out(phase_out), .sync_lost(sync_lost)
    );

    always #5 clk = ~clk;

    // Reference model: phase, clocks since the last line start, and a 3-deep output lag.
    logic [31:0] m_phase;
    logic [31:0] m_line_ftw;
    int          m_since;
    bit          m_hsync_d;
    longint      hist[$];
    bit          m_exp_valid;
    int          m_exp_sin, m_exp_cos;

    function automatic int ref_wave(input logic [31:0] ph, input bit want_cos);
        real ang, v;
        ang = 2.0 * 3.14159265358979323846 * (real'(ph >> 22) + 0.5) / 1024.0;
        v   = want_cos ? $cos(ang) : $sin(ang);
        return int'(2047.0 * v);
    endfunction

    function automatic logic [31:0] line_ftw(input longint off);
        longint c;
        c = off;
        if (c > LIMIT) c = LIMIT;
        if (c < -LIMIT) c = -LIMIT;
        return 32'(longint'(NOM) + c);
    endfunction

    function automatic bit exp_burst();
        return (m_since >= BSTART) && (m_since < BSTART + BLEN);
    endfunction

    task automatic model_reset();
        m_phase     = '0;
        m_line_ftw  = NOM;
        m_since     = MAXL;
        m_hsync_d   = 1'b0;
        hist        = '{-1, -1, 0};
        m_exp_valid = 1'b0;
    endtask

    task automatic step();
        logic [31:0] cur;
        longint      e;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            cur     = (m_since >= MAXL) ? NOM : m_line_ftw;
            m_phase = m_phase + cur;
            if (hsync && !m_hsync_d) begin
                m_since    = 0;
                m_line_ftw = line_ftw(longint'(offset_in));
            end else if (m_since < MAXL) begin
                m_since++;
            end
            m_hsync_d = hsync;
            hist.push_back(longint'(m_phase));
            e = hist.pop_front();
            m_exp_valid = (e >= 0);
            if (m_exp_valid) begin
                m_exp_sin = ref_wave(32'(e), 1'b0);
                m_exp_cos = ref_wave(32'(e), 1'b1);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_checks++; if (phase_out !== 32'd0) $display("FAIL reset_phase got %h want 0", phase_out); else n_pass++;
        n_checks++; if (sin_out !== 12'sd0) $display("FAIL reset_sin got %0d want 0", sin_out); else n_pass++;
        n_checks++; if (cos_out !== 12'sd0) $display("FAIL reset_cos got %0d want 0", cos_out); else n_pass++;
        n_checks++; if (burst_active !== 1'b0) $display("FAIL reset_burst got %b want 0", burst_active); else n_pass++;
        n_checks++; if (sync_lost !== 1'b1) $display("FAIL reset_sync_lost got %b want 1", sync_lost); else n_pass++;
        repeat (3) step();
        n_checks++; if (phase_out !== 32'd0) $display("FAIL reset_hold_phase got %h want 0", phase_out); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (phase_out !== m_phase) $display("FAIL freerun_phase cyc=%0d got %h want %h", i, phase_out, m_phase);
            else n_pass++;
            n_checks++;
            if (sync_lost !== 1'b1) $display("FAIL freerun_sync_lost cyc=%0d got %b want 1", i, sync_lost);
            else n_pass++;
        end
    endtask

    task automatic test_phase_and_wave();
        logic [31:0] p;
        offset_in = '0;
        hsync = 1'b1;
        step();
        hsync = 1'b0;
        p = phase_out;
        repeat (4) step();
        n_checks++;
        if (phase_out - p !== 32'd2277634172)
            $display("FAIL phase_4step got %0d want 2277634172", phase_out - p);
        else n_pass++;
        for (int i = 0; i < 300; i++) begin
            hsync = (i > 150 && i < 150 + int'($urandom_range(1, 6)));
            step();
            n_checks++;
            if (phase_out !== m_phase) $display("FAIL wave_phase cyc=%0d got %h want %h", i, phase_out, m_phase);
            else n_pass++;
            if (m_exp_valid) begin
                n_checks++;
                if (sin_out !== 12'(m_exp_sin)) $display("FAIL wave_sin cyc=%0d got %0d want %0d", i, sin_out, m_exp_sin);
                else n_pass++;
                n_checks++;
                if (cos_out !== 12'(m_exp_cos)) $display("FAIL wave_cos cyc=%0d got %0d want %0d", i, cos_out, m_exp_cos);
                else n_pass++;
            end
        end
        hsync = 1'b0;
        step();
    endtask

    task automatic test_burst_window();
        int w, first, count;
        w = int'($urandom_range(1, 12));
        offset_in = 32'(int'($urandom_range(0, 2 * LIMIT)) - LIMIT);
        first = -1;
        count = 0;
        for (int k = 0; k <= 130; k++) begin
            hsync = (k <= w);
            step();
            n_checks++;
            if (burst_active !== exp_burst()) $display("FAIL burst_window edge=%0d got %b want %b", k, burst_active, exp_burst());
            else n_pass++;
            if (burst_active === 1'b1) begin
                if (first < 0) first = k;
                count++;
            end
        end
        hsync = 1'b0;
        n_checks++; if (first != BSTART) $display("FAIL burst_first got %0d want %0d", first, BSTART); else n_pass++;
        n_checks++; if (count != BLEN) $display("FAIL burst_len got %0d want %0d", count, BLEN); else n_pass++;
    endtask

    task automatic test_offset();
        longint      offs[7];
        logic [31:0] p, want;
        offs = '{1073741824, -1073741824, LIMIT, -LIMIT, LIMIT + 1, -LIMIT - 5, 0};
        offs[6] = longint'($signed($urandom()));
        for (int i = 0; i < 7; i++) begin
            want = (i == 0) ? 32'd586185759 : (i == 1) ? 32'd552631327 : line_ftw(offs[i]);
            offset_in = 32'(offs[i]);
            hsync = 1'b1;
            step();
            hsync = 1'b0;
            p = phase_out;
            step();
            n_checks++;
            if (phase_out - p !== want) $display("FAIL ftw_line%0d got %0d want %0d", i, phase_out - p, want);
            else n_pass++;
            offset_in = $signed($urandom());
            for (int k = 0; k < 12; k++) begin
                step();
                n_checks++;
                if (phase_out !== m_phase) $display("FAIL ftw_track line%0d cyc=%0d got %h want %h", i, k, phase_out, m_phase);
                else n_pass++;
                if (m_exp_valid) begin
                    n_checks++;
                    if (sin_out !== 12'(m_exp_sin)) $display("FAIL ftw_sin line%0d got %0d want %0d", i, sin_out, m_exp_sin);
                    else n_pass++;
                end
            end
            p = phase_out;
            step();
            n_checks++;
            if (phase_out - p !== want) $display("FAIL ftw_midline%0d got %0d want %0d", i, phase_out - p, want);
            else n_pass++;
        end
    endtask

    task automatic test_restart_mid_burst();
        offset_in = '0;
        hsync = 1'b1;
        step();
        for (int k = 1; k <= 185; k++) begin
            hsync = (k <= 3) || (k >= 70 && k <= 72);
            step();
            n_checks++;
            if (burst_active !== exp_burst()) $display("FAIL restart_burst edge=%0d got %b want %b", k, burst_active, exp_burst());
            else n_pass++;
            if (k == 69 || k == 110 || k == 169) begin
                n_checks++;
                if (burst_active !== 1'b1) $display("FAIL restart_high edge=%0d got %b want 1", k, burst_active);
                else n_pass++;
            end
            if (k == 70 || k == 71 || k == 109 || k == 170) begin
                n_checks++;
                if (burst_active !== 1'b0) $display("FAIL restart_low edge=%0d got %b want 0", k, burst_active);
                else n_pass++;
            end
        end
        hsync = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        hsync = 1'b1;
        step();
        hsync = 1'b0;
        repeat (50) step();
        n_checks++; if (burst_active !== 1'b1) $display("FAIL prereset_burst got %b want 1", burst_active); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (burst_active !== 1'b0) $display("FAIL async_rst_burst got %b want 0", burst_active); else n_pass++;
        n_checks++; if (sin_out !== 12'sd0) $display("FAIL async_rst_sin got %0d want 0", sin_out); else n_pass++;
        n_checks++; if (cos_out !== 12'sd0) $display("FAIL async_rst_cos got %0d want 0", cos_out); else n_pass++;
        n_checks++; if (phase_out !== 32'd0) $display("FAIL async_rst_phase got %h want 0", phase_out); else n_pass++;
        n_checks++; if (sync_lost !== 1'b1) $display("FAIL async_rst_sync_lost got %b want 1", sync_lost); else n_pass++;
        step();
        rst = 1'b0;
        for (int k = 0; k < 150; k++) begin
            step();
            n_checks++;
            if (burst_active !== 1'b0) $display("FAIL postreset_no_burst cyc=%0d got %b want 0", k, burst_active);
            else n_pass++;
        end
        hsync = 1'b1;
        step();
        hsync = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            step();
            n_checks++;
            if (burst_active !== exp_burst()) $display("FAIL postreset_burst edge=%0d got %b want %b", k, burst_active, exp_burst());
            else n_pass++;
        end
    endtask

    task automatic test_sync_lost();
        logic [31:0] p;
        offset_in = 32'sd1073741824;
        hsync = 1'b1;
        step();
        hsync = 1'b0;
        n_checks++; if (sync_lost !== 1'b0) $display("FAIL sync_cleared got %b want 0", sync_lost); else n_pass++;
        p = '0;
        for (int k = 1; k <= 2060; k++) begin
            step();
            n_checks++;
            if (sync_lost !== (m_since >= MAXL)) $display("FAIL sync_track edge=%0d got %b want %b", k, sync_lost, m_since >= MAXL);
            else n_pass++;
            if (k == 2047) begin
                n_checks++;
                if (sync_lost !== 1'b0) $display("FAIL sync_edge2047 got %b want 0", sync_lost); else n_pass++;
            end
            if (k == 2048) begin
                n_checks++;
                if (sync_lost !== 1'b1) $display("FAIL sync_edge2048 got %b want 1", sync_lost); else n_pass++;
            end
            if (k == 2051) begin
                n_checks++;
                if (phase_out - p !== NOM) $display("FAIL sync_ftw_nominal got %0d want %0d", phase_out - p, NOM);
                else n_pass++;
            end
            p = phase_out;
        end
        for (int k = 0; k < 100; k++) begin
            step();
            n_checks++;
            if (burst_active !== 1'b0) $display("FAIL lost_idle_burst cyc=%0d got %b want 0", k, burst_active);
            else n_pass++;
        end
        hsync = 1'b1;
        step();
        hsync = 1'b0;
        n_checks++; if (sync_lost !== 1'b0) $display("FAIL sync_relock got %b want 0", sync_lost); else n_pass++;
        for (int k = 1; k <= 45; k++) step();
        n_checks++; if (burst_active !== 1'b1) $display("FAIL relock_burst got %b want 1", burst_active); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_phase_and_wave();
        test_burst_window();
        test_offset();
        test_restart_mid_burst();
        test_reset_mid_burst();
        test_sync_lost();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
